// File: rtl/qa_emul_host_mem_pkg.sv
// Shared header layout, field types and the C1 request record for the host-memory emulator.
package qa_emul_host_mem_pkg;

  localparam int CCI_DATA_WIDTH       = 512;
  localparam int CCI_QLP_TX_HDR_WIDTH = 61;
  localparam int CCI_QLP_RX_HDR_WIDTH = 18;
  localparam int CCI_TAG_WIDTH        = 13;
  localparam int N_LINES_DEF          = 1024;

  localparam int HDR_MDATA_LSB = 0;
  localparam int HDR_ADDR_LSB  = CCI_TAG_WIDTH;
  localparam int HDR_ADDR_W    = 32;

  typedef logic [$clog2(N_LINES_DEF)-1:0] t_line_idx;
  typedef logic [CCI_TAG_WIDTH-1:0]       t_mdata;

  typedef enum logic {
    C1_WR = 1'b0,
    C1_IR = 1'b1
  } t_c1_type;

  typedef struct packed {
    t_c1_type                        typ;
    logic [CCI_QLP_TX_HDR_WIDTH-1:0] hdr;
    logic [CCI_DATA_WIDTH-1:0]       data;
  } t_c1_req;

  function automatic t_mdata hdr_mdata(input logic [CCI_QLP_TX_HDR_WIDTH-1:0] hdr);
    return hdr[HDR_MDATA_LSB +: CCI_TAG_WIDTH];
  endfunction

endpackage

// File: rtl/qa_emul_req_fifo.sv
// Synchronous request FIFO with registered almost-full and a drop indication on full-push.
module qa_emul_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int SLACK = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_en_i,
  output logic         pop_o,
  output logic [W-1:0] dout_o,
  output logic         alm_full_o,
  output logic         overflow_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          alm_full_q;
  logic          full;
  logic          push_ok;

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign pop_o      = pop_en_i && (count_q != '0);
  // A full FIFO still accepts a push in the same cycle it frees a slot.
  assign push_ok    = push_i && (!full || pop_o);
  assign overflow_o = push_i && !push_ok;
  assign dout_o     = mem_q[rd_ptr_q];
  assign alm_full_o = alm_full_q;

  always_comb begin
    count_d = count_q;
    if (push_ok) count_d = count_d + 1'b1;
    if (pop_o)   count_d = count_d - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      alm_full_q <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_o)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      alm_full_q <= ((DEPTH - int'(count_d)) <= SLACK);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/qa_emul_host_mem.sv
// Host-side memory responder: serves C0 reads and C1 writes/interrupts from a line RAM and
// returns CCI-style responses echoing the request Mdata.
module qa_emul_host_mem
  import qa_emul_host_mem_pkg::*;
#(
  parameter int N_LINES        = 1024,
  parameter int READ_LATENCY   = 4,
  parameter int REQ_FIFO_DEPTH = 8,
  parameter int ALM_FULL_SLACK = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            TestStall,
  input  logic                            C0TxRdValid,
  input  logic [CCI_QLP_TX_HDR_WIDTH-1:0] C0TxHdr,
  output logic                            C0TxAlmFull,
  input  logic                            C1TxWrValid,
  input  logic                            C1TxIrValid,
  input  logic [CCI_QLP_TX_HDR_WIDTH-1:0] C1TxHdr,
  input  logic [CCI_DATA_WIDTH-1:0]       C1TxData,
  output logic                            C1TxAlmFull,
  output logic                            C0RxRdValid,
  output logic [CCI_QLP_RX_HDR_WIDTH-1:0] C0RxHdr,
  output logic [CCI_DATA_WIDTH-1:0]       C0RxData,
  output logic                            C1RxWrValid,
  output logic                            C1RxIrValid,
  output logic [CCI_QLP_RX_HDR_WIDTH-1:0] C1RxHdr,
  output logic                            errOverflow
);
  localparam int LIDX_W = $clog2(N_LINES);
  localparam int C0_W   = CCI_TAG_WIDTH + LIDX_W;

  logic              c0_pop, c0_ovf, c1_pop, c1_ovf;
  logic [C0_W-1:0]   c0_din, c0_dout;
  t_mdata            c0_md;
  logic [LIDX_W-1:0] c0_line, c1_line;
  t_c1_req           c1_din, c1_req;

  assign c0_din = {hdr_mdata(C0TxHdr), C0TxHdr[HDR_ADDR_LSB +: LIDX_W]};
  assign {c0_md, c0_line} = c0_dout;

  // Write wins when both C1 valids are raised together.
  assign c1_din  = '{typ: (C1TxWrValid ? C1_WR : C1_IR), hdr: C1TxHdr, data: C1TxData};
  assign c1_line = c1_req.hdr[HDR_ADDR_LSB +: LIDX_W];

  qa_emul_req_fifo #(.W(C0_W), .DEPTH(REQ_FIFO_DEPTH), .SLACK(ALM_FULL_SLACK)) u_c0_fifo (
    .clk(clk), .reset(reset), .push_i(C0TxRdValid), .din_i(c0_din), .pop_en_i(!TestStall),
    .pop_o(c0_pop), .dout_o(c0_dout), .alm_full_o(C0TxAlmFull), .overflow_o(c0_ovf)
  );

  qa_emul_req_fifo #(.W($bits(t_c1_req)), .DEPTH(REQ_FIFO_DEPTH), .SLACK(ALM_FULL_SLACK)) u_c1_fifo (
    .clk(clk), .reset(reset), .push_i(C1TxWrValid || C1TxIrValid), .din_i(c1_din),
    .pop_en_i(!TestStall), .pop_o(c1_pop), .dout_o(c1_req), .alm_full_o(C1TxAlmFull),
    .overflow_o(c1_ovf)
  );

  logic [CCI_DATA_WIDTH-1:0]     ram_q [N_LINES];
  logic [CCI_DATA_WIDTH-1:0]     dat_q [READ_LATENCY];
  t_mdata                        md_q  [READ_LATENCY];
  logic [READ_LATENCY-1:0]       v_q;
  logic                          wr_ack_q, ir_ack_q, err_q;
  t_mdata                        c1_md_q;

  // RAM and read-data pipe carry no reset; nonblocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (c0_pop) dat_q[0] <= ram_q[c0_line];
    if (c1_pop && c1_req.typ == C1_WR) ram_q[c1_line] <= c1_req.data;
    for (int i = 1; i < READ_LATENCY; i++) dat_q[i] <= dat_q[i-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) md_q[i] <= '0;
    end else begin
      v_q[0]  <= c0_pop;
      md_q[0] <= c0_md;
      for (int i = 1; i < READ_LATENCY; i++) begin
        v_q[i]  <= v_q[i-1];
        md_q[i] <= md_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ack_q <= 1'b0;
      ir_ack_q <= 1'b0;
      c1_md_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ack_q <= c1_pop && (c1_req.typ == C1_WR);
      ir_ack_q <= c1_pop && (c1_req.typ == C1_IR);
      if (c1_pop) c1_md_q <= hdr_mdata(c1_req.hdr);
      err_q    <= err_q || c0_ovf || c1_ovf;
    end
  end

  assign C0RxRdValid = v_q[READ_LATENCY-1];
  assign C0RxHdr     = CCI_QLP_RX_HDR_WIDTH'(md_q[READ_LATENCY-1]);
  assign C0RxData    = v_q[READ_LATENCY-1] ? dat_q[READ_LATENCY-1] : '0;
  assign C1RxWrValid = wr_ack_q;
  assign C1RxIrValid = ir_ack_q;
  assign C1RxHdr     = CCI_QLP_RX_HDR_WIDTH'(c1_md_q);
  assign errOverflow = err_q;

  logic unused_hdr_bits;
  assign unused_hdr_bits = ^{C0TxHdr[CCI_QLP_TX_HDR_WIDTH-1:HDR_ADDR_LSB+LIDX_W],
                             c1_req.hdr[CCI_QLP_TX_HDR_WIDTH-1:HDR_ADDR_LSB+LIDX_W]};

endmodule
